// File: rtl/mem_access.sv
// Load/store stage: drives the data bus for one access at a time and produces the writeback beat.
// Optional alignment trap: define MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access #(
   parameter int TIMEOUT_CYC = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_we,
   input  logic [4:0]  mem_waddr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_sdata,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_be,
   output logic [31:0] dbus_wdata,
   input  logic [31:0] dbus_rdata,
   input  logic        dbus_ack,
   output logic        wb_we,
   output logic [4:0]  wb_waddr,
   output logic [31:0] wb_wdata,
   output logic        stall_req,
   output logic        excp_misalign,
   output logic        excp_buserr
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                          OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

   state_t      state;
   logic [7:0]  cnt;
   logic [3:0]  op_q;
   logic [1:0]  off_q;
   logic        misalign_q;

   logic        is_load, is_store, is_ls, misalign, timeout;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt, load_res;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      is_load   = (mem_op >= OP_LB) && (mem_op <= OP_LW);
      is_store  = (mem_op >= OP_SB) && (mem_op <= OP_SW);
      is_ls     = is_load || is_store;
      be_nxt    = 4'b1111;
      wdata_nxt = mem_sdata;
      case (mem_op)
         OP_SB: begin
            be_nxt    = 4'b0001 << mem_addr[1:0];
            wdata_nxt = {4{mem_sdata[7:0]}};
         end
         OP_SH: begin
            be_nxt    = mem_addr[1] ? 4'b1100 : 4'b0011;
            wdata_nxt = {2{mem_sdata[15:0]}};
         end
         default: ;
      endcase
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      misalign = ((mem_op == OP_LH || mem_op == OP_LHU || mem_op == OP_SH) && mem_addr[0]) ||
                 ((mem_op == OP_LW || mem_op == OP_SW) && (mem_addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
   end

   // Lane extraction uses the offset and op latched at request time.
   always_comb begin
      rd_byte  = dbus_rdata[8*off_q +: 8];
      rd_half  = off_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
      load_res = dbus_rdata;
      case (op_q)
         OP_LB:   load_res = {{24{rd_byte[7]}}, rd_byte};
         OP_LBU:  load_res = {24'd0, rd_byte};
         OP_LH:   load_res = {{16{rd_half[15]}}, rd_half};
         OP_LHU:  load_res = {16'd0, rd_half};
         default: load_res = dbus_rdata;
      endcase
   end

   assign timeout   = (cnt == 8'(TIMEOUT_CYC - 1));
   assign stall_req = (state == IDLE && is_ls && !misalign) ||
                      (state == BUSY && !dbus_ack && !timeout);
   assign excp_misalign = misalign_q;

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         op_q        <= '0;
         off_q       <= '0;
         dbus_req    <= 1'b0;
         dbus_we     <= 1'b0;
         dbus_addr   <= '0;
         dbus_be     <= '0;
         dbus_wdata  <= '0;
         wb_we       <= 1'b0;
         wb_waddr    <= '0;
         wb_wdata    <= '0;
         misalign_q  <= 1'b0;
         excp_buserr <= 1'b0;
      end else begin
         misalign_q  <= 1'b0;
         excp_buserr <= 1'b0;
         case (state)
            IDLE: begin
               if (is_ls && misalign) begin
                  wb_we      <= 1'b0;
                  misalign_q <= 1'b1;
               end else if (is_ls) begin
                  dbus_req   <= 1'b1;
                  dbus_we    <= is_store;
                  dbus_addr  <= {mem_addr[31:2], 2'b00};
                  dbus_be    <= be_nxt;
                  dbus_wdata <= wdata_nxt;
                  op_q       <= mem_op;
                  off_q      <= mem_addr[1:0];
                  cnt        <= '0;
                  wb_we      <= 1'b0;
                  state      <= BUSY;
               end else begin
                  wb_we    <= mem_we;
                  wb_waddr <= mem_waddr;
                  wb_wdata <= mem_wdata;
               end
            end
            BUSY: begin
               // Ack takes priority over a timeout landing in the same cycle.
               if (dbus_ack) begin
                  wb_we    <= mem_we;
                  wb_waddr <= mem_waddr;
                  wb_wdata <= (op_q <= OP_LW) ? load_res : mem_wdata;
                  dbus_req <= 1'b0;
                  dbus_we  <= 1'b0;
                  state    <= IDLE;
               end else if (timeout) begin
                  excp_buserr <= 1'b1;
                  wb_we       <= 1'b0;
                  dbus_req    <= 1'b0;
                  dbus_we     <= 1'b0;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: passthrough, loads/stores, timeout, alignment and reset.
module tb_mem_access;

   localparam int TO = 4;
   localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3,
                          LW = 4'd5, SB = 4'd6, SH = 4'd7;

   logic        clk = 1'b0, rst = 1'b0;
   logic        mem_we = 1'b0;
   logic [4:0]  mem_waddr = '0;
   logic [31:0] mem_wdata = '0, mem_addr = '0, mem_sdata = '0, dbus_rdata = '0;
   logic [3:0]  mem_op = NONE;
   logic        dbus_ack = 1'b0;
   logic        dbus_req, dbus_we, wb_we, stall_req, excp_misalign, excp_buserr;
   logic [31:0] dbus_addr, dbus_wdata, wb_wdata;
   logic [3:0]  dbus_be;
   logic [4:0]  wb_waddr;

   int total = 0, bad = 0;

   mem_access #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
      .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .stall_req(stall_req), .excp_misalign(excp_misalign), .excp_buserr(excp_buserr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic we, input logic [4:0] waddr, input logic [31:0] wdata);
      mem_op = op; mem_addr = addr; mem_sdata = sdata;
      mem_we = we; mem_waddr = waddr; mem_wdata = wdata;
   endtask

   // One access acked in its first BUSY cycle; store data checked only for stores.
   task automatic txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] sdata, input logic we, input logic [4:0] waddr,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input logic [31:0] exp_addr, input logic [3:0] exp_be,
                      input logic [31:0] exp_dw, input logic [31:0] exp_wb);
      logic st;
      st = (op >= SB);
      drive(op, addr, sdata, we, waddr, wdata);
      #1 check({tag, ".stall_idle"}, 32'(stall_req), 32'd1);
      tick();
      check({tag, ".req"}, 32'(dbus_req), 32'd1);
      check({tag, ".addr"}, dbus_addr, exp_addr);
      check({tag, ".be"}, 32'(dbus_be), 32'(exp_be));
      check({tag, ".dwe"}, 32'(dbus_we), 32'(st));
      if (st) check({tag, ".dwdata"}, dbus_wdata, exp_dw);
      check({tag, ".bubble"}, 32'(wb_we), 32'd0);
      check({tag, ".stall_busy"}, 32'(stall_req), 32'd1);
      dbus_ack = 1'b1; dbus_rdata = rdata;
      #1 check({tag, ".stall_ack"}, 32'(stall_req), 32'd0);
      tick();
      dbus_ack = 1'b0; mem_op = NONE;
      check({tag, ".wb_we"}, 32'(wb_we), 32'(we));
      check({tag, ".wb_waddr"}, 32'(wb_waddr), 32'(waddr));
      check({tag, ".wb_wdata"}, wb_wdata, exp_wb);
      check({tag, ".req_drop"}, 32'(dbus_req), 32'd0);
   endtask

   initial begin
      #2;
      check("rst.dbus_req", 32'(dbus_req), 32'd0);
      check("rst.dbus_addr", dbus_addr, 32'd0);
      check("rst.dbus_be", 32'(dbus_be), 32'd0);
      check("rst.wb_we", 32'(wb_we), 32'd0);
      check("rst.wb_wdata", wb_wdata, 32'd0);
      check("rst.excp", {30'd0, excp_misalign, excp_buserr}, 32'd0);
      #10 rst = 1'b1;

      // Passthrough, with a stray ack that must be ignored in IDLE
      drive(NONE, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234);
      dbus_ack = 1'b1;
      #1 check("none.stall", 32'(stall_req), 32'd0);
      tick();
      dbus_ack = 1'b0;
      check("none.wb_we", 32'(wb_we), 32'd1);
      check("none.wb_waddr", 32'(wb_waddr), 32'd5);
      check("none.wb_wdata", wb_wdata, 32'h1234);
      check("none.req", 32'(dbus_req), 32'd0);

      txn("lb", LB, 32'h103, 32'h0, 1'b1, 5'd7, 32'hDEAD, 32'h80FF_FFFF,
          32'h100, 4'b1111, 32'h0, 32'hFFFF_FF80);
      txn("sh", SH, 32'h22, 32'h0000_ABCD, 1'b0, 5'd3, 32'h55, 32'h0,
          32'h20, 4'b1100, 32'hABCD_ABCD, 32'h55);
      txn("lbu", LBU, 32'h101, 32'h0, 1'b1, 5'd9, 32'h0, 32'h1234_8A56,
          32'h100, 4'b1111, 32'h0, 32'h0000_008A);
      txn("lh", LH, 32'h2, 32'h0, 1'b1, 5'd10, 32'h0, 32'h8001_0000,
          32'h0, 4'b1111, 32'h0, 32'hFFFF_8001);
      txn("sb", SB, 32'h1, 32'h0000_00EF, 1'b1, 5'd11, 32'hCAFE, 32'h0,
          32'h0, 4'b0010, 32'hEFEF_EFEF, 32'hCAFE);

      // Timeout: no ack for TO BUSY cycles
      drive(LW, 32'h200, 32'h0, 1'b1, 5'd12, 32'h77);
      tick();
      for (int i = 0; i < TO - 1; i++) begin
         check("to.stall_hold", 32'(stall_req), 32'd1);
         tick();
      end
      check("to.stall_release", 32'(stall_req), 32'd0);
      tick();
      mem_op = NONE;
      check("to.buserr", 32'(excp_buserr), 32'd1);
      check("to.wb_we", 32'(wb_we), 32'd0);
      check("to.req", 32'(dbus_req), 32'd0);
      tick();
      check("to.buserr_pulse", 32'(excp_buserr), 32'd0);

      // Ack arriving in the timeout cycle wins
      drive(LW, 32'h300, 32'h0, 1'b1, 5'd13, 32'h0);
      tick();
      for (int i = 0; i < TO - 1; i++) tick();
      dbus_ack = 1'b1; dbus_rdata = 32'h1357_2468;
      tick();
      dbus_ack = 1'b0; mem_op = NONE;
      check("race.buserr", 32'(excp_buserr), 32'd0);
      check("race.wb_we", 32'(wb_we), 32'd1);
      check("race.wb_wdata", wb_wdata, 32'h1357_2468);

      // Misaligned word load
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      drive(LW, 32'h102, 32'h0, 1'b1, 5'd14, 32'h0);
      #1 check("mis.stall", 32'(stall_req), 32'd0);
      tick();
      mem_op = NONE;
      check("mis.req", 32'(dbus_req), 32'd0);
      check("mis.excp", 32'(excp_misalign), 32'd1);
      check("mis.wb_we", 32'(wb_we), 32'd0);
      tick();
      check("mis.pulse", 32'(excp_misalign), 32'd0);
`else
      txn("mis", LW, 32'h102, 32'h0, 1'b1, 5'd14, 32'h0, 32'hA5A5_0F0F,
          32'h100, 4'b1111, 32'h0, 32'hA5A5_0F0F);
      check("mis.excp", 32'(excp_misalign), 32'd0);
`endif

      // Reset in the middle of a BUSY access
      drive(LW, 32'h400, 32'h0, 1'b1, 5'd15, 32'h0);
      tick();
      check("rb.req_busy", 32'(dbus_req), 32'd1);
      #3 rst = 1'b0;
      #1 check("rb.req_async", 32'(dbus_req), 32'd0);
      check("rb.wb_we", 32'(wb_we), 32'd0);
      mem_op = NONE;
      tick();
      check("rb.held", 32'(wb_we), 32'd0);
      rst = 1'b1;
      drive(NONE, 32'h0, 32'h0, 1'b1, 5'd21, 32'hBEEF);
      tick();
      check("rb.resume_we", 32'(wb_we), 32'd1);
      check("rb.resume_data", wb_wdata, 32'hBEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
